// File: rtl/branch_predictor.sv
// ============================================================================
// Module      : branch_predictor
// Description : Direct-mapped 2-bit saturating-counter branch direction
//               predictor with registered D-stage lookup and resolve port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      pc_f,
  input  logic             lookup_f,
  input  logic             stall_d,
  input  logic             flush_d,
  output logic             pred_valid_d,
  output logic             pred_taken_d,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred,
  output logic             mispredict,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_misses
);

  localparam int               c_entries   = 1 << INDEX_BITS;
  localparam logic [1:0]       c_weak_nt   = 2'b01;
  localparam logic [CNT_W-1:0] c_cnt_one   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]            r_table [c_entries];
  logic                  r_pred_valid;
  logic                  r_pred_taken;
  logic [CNT_W-1:0]      r_stat_branches;
  logic [CNT_W-1:0]      r_stat_misses;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [1:0]            w_up_cur;
  logic [1:0]            w_up_next;
  logic                  w_mispredict;

  assign w_lk_idx     = pc_f[INDEX_BITS+1:2];
  assign w_up_idx     = upd_pc[INDEX_BITS+1:2];
  assign w_up_cur     = r_table[w_up_idx];
  assign w_mispredict = upd_valid & (upd_taken ^ upd_pred);

  always_comb begin
    w_up_next = w_up_cur;
    if (upd_taken) begin
      if (w_up_cur != 2'b11) w_up_next = w_up_cur + 2'b01;
    end else begin
      if (w_up_cur != 2'b00) w_up_next = w_up_cur - 2'b01;
    end
  end

  // Lookup reads the table before this edge's update lands, so a
  // same-cycle lookup/update pair sees the old counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < c_entries; i++) r_table[i] <= c_weak_nt;
      r_pred_valid    <= 1'b0;
      r_pred_taken    <= 1'b0;
      r_stat_branches <= '0;
      r_stat_misses   <= '0;
    end else begin
      if (flush_d) begin
        r_pred_valid <= 1'b0;
        r_pred_taken <= 1'b0;
      end else if (!stall_d) begin
        r_pred_valid <= lookup_f;
        r_pred_taken <= lookup_f & r_table[w_lk_idx][1];
      end
      if (upd_valid) begin
        r_table[w_up_idx] <= w_up_next;
        r_stat_branches   <= r_stat_branches + c_cnt_one;
        if (w_mispredict) r_stat_misses <= r_stat_misses + c_cnt_one;
      end
    end
  end

  assign pred_valid_d  = r_pred_valid;
  assign pred_taken_d  = r_pred_taken;
  assign mispredict    = w_mispredict;
  assign stat_branches = r_stat_branches;
  assign stat_misses   = r_stat_misses;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module      : tb_branch_predictor
// Description : Directed self-checking bench for branch_predictor; a second
//               narrow-counter instance shares the stimulus to reach wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;

  logic        clk;
  logic        resetn;
  logic [31:0] pc_f;
  logic        lookup_f;
  logic        stall_d;
  logic        flush_d;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;

  logic        pred_valid_d;
  logic        pred_taken_d;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_misses;

  logic        w_pred_valid_d;
  logic        w_pred_taken_d;
  logic        w_mispredict;
  logic [3:0]  w_stat_branches;
  logic [3:0]  w_stat_misses;

  int n_checks = 0;
  int n_errors = 0;

  branch_predictor dut (
    .clk(clk), .resetn(resetn), .pc_f(pc_f), .lookup_f(lookup_f),
    .stall_d(stall_d), .flush_d(flush_d),
    .pred_valid_d(pred_valid_d), .pred_taken_d(pred_taken_d),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .mispredict(mispredict),
    .stat_branches(stat_branches), .stat_misses(stat_misses)
  );

  branch_predictor #(.INDEX_BITS(6), .CNT_W(4)) dut_w (
    .clk(clk), .resetn(resetn), .pc_f(pc_f), .lookup_f(lookup_f),
    .stall_d(stall_d), .flush_d(flush_d),
    .pred_valid_d(w_pred_valid_d), .pred_taken_d(w_pred_taken_d),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_pred(upd_pred), .mispredict(w_mispredict),
    .stat_branches(w_stat_branches), .stat_misses(w_stat_misses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_f  = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    upd_valid = 1'b0;
    upd_taken = 1'b0;
    upd_pred  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic pred);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_pred = pred;
    cyc();
    upd_valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc);
    lookup_f = 1'b1; pc_f = pc;
    cyc();
    lookup_f = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lookup(32'h0040_0010);
    n_checks++;
    if (pred_valid_d !== 1'b1) begin n_errors++; $display("FAIL reset_valid: got %b want 1", pred_valid_d); end
    n_checks++;
    if (pred_taken_d !== 1'b0) begin n_errors++; $display("FAIL reset_taken: got %b want 0", pred_taken_d); end
    n_checks++;
    if (stat_branches !== 32'd0) begin n_errors++; $display("FAIL reset_branches: got %0d want 0", stat_branches); end
    n_checks++;
    if (stat_misses !== 32'd0) begin n_errors++; $display("FAIL reset_misses: got %0d want 0", stat_misses); end
  endtask

  task automatic test_training();
    update(32'h0040_0010, 1'b1, 1'b0);
    update(32'h0040_0010, 1'b1, 1'b1);
    lookup(32'h0040_0010);
    n_checks++;
    if (pred_taken_d !== 1'b1) begin n_errors++; $display("FAIL train_11: got %b want 1", pred_taken_d); end
    update(32'h0040_0010, 1'b1, 1'b1);
    update(32'h0040_0010, 1'b0, 1'b1);
    lookup(32'h0040_0010);
    n_checks++;
    if (pred_taken_d !== 1'b1) begin n_errors++; $display("FAIL train_sat_hi: got %b want 1", pred_taken_d); end
    update(32'h0040_0010, 1'b0, 1'b1);
    lookup(32'h0040_0010);
    n_checks++;
    if (pred_taken_d !== 1'b0) begin n_errors++; $display("FAIL train_01: got %b want 0", pred_taken_d); end
    update(32'h0040_0010, 1'b0, 1'b0);
    update(32'h0040_0010, 1'b0, 1'b0);
    update(32'h0040_0010, 1'b1, 1'b0);
    lookup(32'h0040_0010);
    n_checks++;
    if (pred_taken_d !== 1'b0) begin n_errors++; $display("FAIL train_sat_lo: got %b want 0", pred_taken_d); end
    update(32'h0040_0010, 1'b1, 1'b0);
    lookup(32'h0040_0010);
    n_checks++;
    if (pred_taken_d !== 1'b1) begin n_errors++; $display("FAIL train_10: got %b want 1", pred_taken_d); end
  endtask

  task automatic test_mispredict();
    do_reset();
    upd_valid = 1'b1; upd_pc = 32'h0000_0020; upd_taken = 1'b1; upd_pred = 1'b0;
    #1;
    n_checks++;
    if (mispredict !== 1'b1) begin n_errors++; $display("FAIL mp_comb: got %b want 1", mispredict); end
    cyc();
    n_checks++;
    if (stat_misses !== 32'd1) begin n_errors++; $display("FAIL mp_misses: got %0d want 1", stat_misses); end
    n_checks++;
    if (stat_branches !== 32'd1) begin n_errors++; $display("FAIL mp_branches: got %0d want 1", stat_branches); end
    upd_taken = 1'b1; upd_pred = 1'b1;
    #1;
    n_checks++;
    if (mispredict !== 1'b0) begin n_errors++; $display("FAIL mp_match: got %b want 0", mispredict); end
    cyc();
    upd_valid = 1'b0; upd_taken = 1'b1; upd_pred = 1'b0;
    #1;
    n_checks++;
    if (mispredict !== 1'b0) begin n_errors++; $display("FAIL mp_invalid: got %b want 0", mispredict); end
    cyc();
    n_checks++;
    if (stat_branches !== 32'd2) begin n_errors++; $display("FAIL mp_branches2: got %0d want 2", stat_branches); end
    n_checks++;
    if (stat_misses !== 32'd1) begin n_errors++; $display("FAIL mp_misses2: got %0d want 1", stat_misses); end
    idle();
  endtask

  task automatic test_stall_flush();
    // Entry for 0x20 was trained to strong taken; entry 0 is still weak NT.
    lookup(32'h0000_0020);
    n_checks++;
    if (pred_taken_d !== 1'b1) begin n_errors++; $display("FAIL stall_pre: got %b want 1", pred_taken_d); end
    stall_d = 1'b1; lookup_f = 1'b1; pc_f = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (pred_valid_d !== 1'b1 || pred_taken_d !== 1'b1) begin
        n_errors++; $display("FAIL stall_hold%0d: got v=%b t=%b want v=1 t=1", i, pred_valid_d, pred_taken_d);
      end
    end
    flush_d = 1'b1;
    cyc();
    n_checks++;
    if (pred_valid_d !== 1'b0 || pred_taken_d !== 1'b0) begin
      n_errors++; $display("FAIL flush_over_stall: got v=%b t=%b want v=0 t=0", pred_valid_d, pred_taken_d);
    end
    idle();
    cyc();
    n_checks++;
    if (pred_valid_d !== 1'b0) begin n_errors++; $display("FAIL no_lookup: got %b want 0", pred_valid_d); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    lookup_f = 1'b1; pc_f = 32'h0040_0014;
    upd_valid = 1'b1; upd_pc = 32'h0040_0014; upd_taken = 1'b1; upd_pred = 1'b0;
    cyc();
    idle();
    n_checks++;
    if (pred_valid_d !== 1'b1 || pred_taken_d !== 1'b0) begin
      n_errors++; $display("FAIL same_cycle: got v=%b t=%b want v=1 t=0", pred_valid_d, pred_taken_d);
    end
    lookup(32'h0040_0114);
    n_checks++;
    if (pred_taken_d !== 1'b1) begin n_errors++; $display("FAIL alias_next: got %b want 1", pred_taken_d); end
    lookup(32'h0040_0018);
    n_checks++;
    if (pred_taken_d !== 1'b0) begin n_errors++; $display("FAIL neighbour: got %b want 0", pred_taken_d); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    for (int i = 0; i < 15; i++) update(32'h0000_0040, 1'b0, 1'b0);
    n_checks++;
    if (w_stat_branches !== 4'd15) begin n_errors++; $display("FAIL wrap_pre: got %0d want 15", w_stat_branches); end
    update(32'h0000_0040, 1'b0, 1'b0);
    n_checks++;
    if (w_stat_branches !== 4'd0) begin n_errors++; $display("FAIL wrap: got %0d want 0", w_stat_branches); end
    n_checks++;
    if (w_stat_misses !== 4'd0) begin n_errors++; $display("FAIL wrap_misses: got %0d want 0", w_stat_misses); end
    n_checks++;
    if (stat_branches !== 32'd16) begin n_errors++; $display("FAIL wide_branches: got %0d want 16", stat_branches); end
    update(32'h0040_0010, 1'b1, 1'b0);
    update(32'h0040_0010, 1'b1, 1'b0);
    // Reset must beat a concurrent lookup and update.
    resetn = 1'b0; lookup_f = 1'b1; pc_f = 32'h0040_0010;
    upd_valid = 1'b1; upd_pc = 32'h0040_0010; upd_taken = 1'b1; upd_pred = 1'b0;
    cyc();
    resetn = 1'b1;
    idle();
    n_checks++;
    if (pred_valid_d !== 1'b0) begin n_errors++; $display("FAIL rst_mid_valid: got %b want 0", pred_valid_d); end
    n_checks++;
    if (stat_branches !== 32'd0 || stat_misses !== 32'd0) begin
      n_errors++; $display("FAIL rst_mid_stats: got b=%0d m=%0d want 0 0", stat_branches, stat_misses);
    end
    lookup(32'h0040_0010);
    n_checks++;
    if (pred_valid_d !== 1'b1 || pred_taken_d !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_lookup: got v=%b t=%b want v=1 t=0", pred_valid_d, pred_taken_d);
    end
  endtask

  initial begin
    resetn = 1'b0;
    pc_f   = 32'h0;
    upd_pc = 32'h0;
    idle();
    @(negedge clk);
    test_reset();
    test_training();
    test_mispredict();
    test_stall_flush();
    test_same_cycle();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
